// File: rtl/mux_sync_tx_sched.sv
// ---------------------------------------------------------------------------
// mux_sync_tx_sched
//
// Source-domain scheduler for a shared multi-bit MUX-synchronizer channel.
// Several requesters in the clk_a domain compete for one DW-bit data bus plus
// a data-enable qualifier. A round-robin arbiter picks a winner while the
// scheduler is idle. The winner's data is captured into a holding register,
// and data_en is driven high for HOLD_CYC cycles. A GAP_CYC quiet period
// follows, so the destination's two-flop enable synchronizer sees every
// transfer as a separate pulse, and the held data is stable when the delayed
// enable samples it.
//
// Ports:
//   clk_a    in   1          sole clock, rising edge
//   arstn    in   1          asynchronous active-low reset
//   req      in   NREQ       level request per requester
//   din      in   NREQ*DW    requester i data on din[i*DW +: DW]
//   gnt      out  NREQ       one-hot, single-cycle grant pulse
//   data_in  out  DW         held data towards the synchronizer
//   data_en  out  1          transfer-valid towards the synchronizer
//   src_id   out  IDW        index of the last granted requester
//   busy     out  1          high while a transfer (HOLD or GAP) is in flight
// ---------------------------------------------------------------------------
module mux_sync_tx_sched #(
    parameter int NREQ     = 4,
    parameter int DW       = 4,
    parameter int HOLD_CYC = 4,
    parameter int GAP_CYC  = 4,
    parameter int IDW      = $clog2(NREQ)
) (
    input  logic                 clk_a,
    input  logic                 arstn,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   din,
    output logic [NREQ-1:0]      gnt,
    output logic [DW-1:0]        data_in,
    output logic                 data_en,
    output logic [IDW-1:0]       src_id,
    output logic                 busy
);

    // The counter only ever holds HOLD_CYC-1 or GAP_CYC-1 as its largest value.
    localparam int MAX_CYC = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [1:0]     state;
    logic [CW-1:0]  cnt;
    logic [IDW-1:0] ptr;

    logic           found;
    logic [IDW-1:0] winner;

    // Round-robin search. Requesters are scanned upward starting at ptr, and
    // the scan wraps from NREQ-1 back to 0. The first set request wins.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

    // Transfer sequencer. A grant is only issued from IDLE.
    // In HOLD, data_en stays high for HOLD_CYC cycles. GAP then keeps the
    // channel quiet for GAP_CYC cycles while data_in remains frozen, so the
    // destination samples settled data after its synchronizer delay.
    // gnt defaults low on every edge, which makes it a single-cycle pulse.
    always_ff @(posedge clk_a or negedge arstn) begin
        if (!arstn) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            ptr     <= '0;
            gnt     <= '0;
            data_in <= '0;
            data_en <= 1'b0;
            src_id  <= '0;
            busy    <= 1'b0;
        end else begin
            gnt <= '0;
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        gnt     <= NREQ'(1) << winner;
                        data_in <= din[int'(winner)*DW +: DW];
                        src_id  <= winner;
                        data_en <= 1'b1;
                        busy    <= 1'b1;
                        ptr     <= (winner == IDW'(NREQ-1)) ? '0 : winner + 1'b1;
                        cnt     <= CW'(HOLD_CYC-1);
                        state   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        data_en <= 1'b0;
                        cnt     <= CW'(GAP_CYC-1);
                        state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    data_en <= 1'b0;
                    busy    <= 1'b0;
                    cnt     <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/mux_sync_tx_sched.md
Name: mux_sync_tx_sched

Overview:
- Source-domain scheduler that shares one multi-bit MUX-synchronizer channel (4-bit data plus a data-enable qualifier) among several requesters.
- Arbitrates round-robin and captures the winner's data into a stable holding register.
- Drives the enable for a programmed number of cycles, then forces a quiet gap. The gap lets the destination's two-flop enable synchronizer see every transfer and lets the data settle before the next one.
- Sits between requester logic in the clk_a domain and the synchronizer's data_in/data_en inputs.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 4, data width per requester.
- HOLD_CYC, 4, clk_a cycles data_en stays high per transfer (>=1).
- GAP_CYC, 4, clk_a cycles data_en stays low after each transfer before the next grant can be issued (>=1).
- IDW, $clog2(NREQ), requester-index width. Derived; not overridden.

Ports:
- clk_a input 1: sole clock, rising edge.
- arstn input 1: asynchronous, active-low reset.
- req input NREQ: level request per requester.
- din input NREQ*DW: requester i data on bits [i*DW +: DW].
- gnt output NREQ: one-hot, one-cycle grant pulse.
- data_in output DW: held data towards the synchronizer.
- data_en output 1: transfer-valid towards the synchronizer.
- src_id output IDW: index of the last granted requester.
- busy output 1: high while in HOLD or GAP.

Behaviour:
- Reset (arstn low, asynchronous):
  - gnt=0, data_in=0, data_en=0, src_id=0, busy=0.
  - Round-robin pointer ptr=0; state=IDLE; counter cleared.
- All outputs are registered. States are IDLE, HOLD and GAP.
- IDLE, req!=0 sampled at edge t0:
  - The winner is the first set req bit scanning upward from ptr, wrapping at NREQ-1 to 0.
  - At t0: gnt<=onehot(winner), data_in<=din slice of the winner, src_id<=winner, data_en<=1, busy<=1.
  - Also at t0: ptr<=(winner+1) mod NREQ, cnt<=HOLD_CYC-1, state<=HOLD.
- IDLE, req==0: outputs hold; data_in and src_id keep their last values.
- Grant handshake:
  - gnt is high for exactly the one cycle following t0.
  - din is captured at t0, so a requester may change din or drop req once it sees gnt.
  - A req dropped before being granted is simply not served; there is no memory of past requests.
- HOLD:
  - data_en=1; data_in is frozen regardless of din/req activity; gnt=0.
  - Each edge: if cnt!=0, decrement; else data_en<=0, cnt<=GAP_CYC-1, state<=GAP.
- GAP:
  - data_en=0; data_in is still held, so the destination samples stable data after its delayed enable.
  - Each edge: if cnt!=0, decrement; else busy<=0, state<=IDLE.
- Timing:
  - data_en is high for exactly HOLD_CYC cycles starting the cycle after t0.
  - busy is high for HOLD_CYC+GAP_CYC cycles.
  - The earliest next grant edge is t0+HOLD_CYC+GAP_CYC+1 (one IDLE cycle is mandatory).
- Requests arriving during HOLD/GAP wait; they are arbitrated at the first IDLE edge. A grant never occurs outside IDLE.
- Fairness: with all req held high, grants rotate 0,1,...,NREQ-1,0, and no requester waits more than NREQ grants.
- ptr wraps NREQ-1 -> 0. The counter width is sized for max(HOLD_CYC,GAP_CYC)-1, with no overflow.
- Reset mid-operation:
  - Immediate return to reset values, including data_en=0 and ptr=0.
  - A transfer cut short is not resumed.

Test Plan:
- Apply reset with req=4'hF and din toggling -> during and after reset gnt=0, data_en=0, data_in=0, busy=0 until the first edge after arstn rises.
- req=4'b0100, din slice2=4'hA (HOLD=GAP=4) -> gnt=4'b0100 for 1 cycle; data_in=4'hA; src_id=2; data_en high 4 cycles then low; busy high 8 cycles; data_in stays 4'hA afterward.
- req=4'hF held, din slices 1,2,3,4 -> grants 0,1,2,3,0 in order; grant edges spaced 9 cycles; data_in sequence 1,2,3,4,1.
- After a grant to 1 (ptr=2), req=4'b1010 -> next grant goes to 3, then to 1 on the following transfer.
- Change din slice and drop/raise req during HOLD and GAP -> data_in, src_id and the data_en timing are unchanged; no extra gnt pulse.
- Drop arstn at the 2nd HOLD cycle -> data_en=0 and data_in=0 asynchronously; after release with req=4'b0010, the grant goes to 1 with full HOLD_CYC enable.
